// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported backing memory between the fetch (I) and data (D) ports.
// Data has priority, a starvation counter guarantees fetch progress, and a flush drops an in-flight fetch.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int TIMEOUT      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iReq,
    input  logic [15:0] iAddr,
    input  logic        iFlush,
    input  logic        dReq,
    input  logic        dWr,
    input  logic [15:0] dAddr,
    input  logic [15:0] dWrData,
    output logic        memEn,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWrData,
    input  logic [15:0] memRdData,
    input  logic        memDone,
    output logic        iDone,
    output logic [15:0] iData,
    output logic        iStall,
    output logic        dDone,
    output logic [15:0] dData,
    output logic        dStall,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} stateT;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    stateT      state;
    logic [3:0] starveCnt;
    logic [7:0] toCnt;
    logic       drop;
    logic       iCand;
    logic       canGrant;
    logic       grantI;
    logic       grantD;
    logic       timeout;

    assign iStall = iReq & ~iDone;
    assign dStall = dReq & ~dDone;

    // A fetch flushed in the same cycle is not a candidate at all.
    assign iCand    = iReq & ~iFlush;
    assign canGrant = (state == IDLE) & ~iDone & ~dDone & ~err;
    assign grantD   = canGrant & dReq & (~iCand | (starveCnt < STARVE_MAX));
    assign grantI   = canGrant & iCand & (~dReq | (starveCnt >= STARVE_MAX));
    assign timeout  = (state != IDLE) & ~memDone & (toCnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            memEn     <= 1'b0;
            memWr     <= 1'b0;
            memAddr   <= '0;
            memWrData <= '0;
            iDone     <= 1'b0;
            dDone     <= 1'b0;
            iData     <= '0;
            dData     <= '0;
            err       <= 1'b0;
            starveCnt <= '0;
            toCnt     <= '0;
            drop      <= 1'b0;
        end else begin
            memEn <= 1'b0;
            iDone <= 1'b0;
            dDone <= 1'b0;
            if (grantD | grantI) begin
                state     <= grantD ? D_BUSY : I_BUSY;
                memEn     <= 1'b1;
                memWr     <= grantD & dWr;
                memAddr   <= grantD ? dAddr : iAddr;
                memWrData <= grantD ? dWrData : memWrData;
                starveCnt <= grantI ? '0 : (iCand ? starveCnt + 4'd1 : starveCnt);
            end
            if (state == IDLE && memDone)
                err <= 1'b1;
            if (state != IDLE) begin
                if (memDone) begin
                    state <= IDLE;
                    toCnt <= '0;
                    drop  <= 1'b0;
                    if (state == D_BUSY) begin
                        dDone <= 1'b1;
                        if (!memWr)
                            dData <= memRdData;
                    end else if (!(drop | iFlush)) begin
                        iDone <= 1'b1;
                        iData <= memRdData;
                    end
                end else if (timeout) begin
                    err   <= 1'b1;
                    state <= IDLE;
                    toCnt <= '0;
                    drop  <= 1'b0;
                end else begin
                    toCnt <= toCnt + 8'd1;
                    if (state == I_BUSY && iFlush)
                        drop <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tasks for the I/D memory port arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iReq = 1'b0;
    logic [15:0] iAddr = '0;
    logic        iFlush = 1'b0;
    logic        dReq = 1'b0;
    logic        dWr = 1'b0;
    logic [15:0] dAddr = '0;
    logic [15:0] dWrData = '0;
    logic        memEn;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWrData;
    logic [15:0] memRdData = '0;
    logic        memDone = 1'b0;
    logic        iDone;
    logic [15:0] iData;
    logic        iStall;
    logic        dDone;
    logic [15:0] dData;
    logic        dStall;
    logic        err;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iFlush(iFlush),
        .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWrData(dWrData),
        .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memWrData(memWrData),
        .memRdData(memRdData), .memDone(memDone),
        .iDone(iDone), .iData(iData), .iStall(iStall),
        .dDone(dDone), .dData(dData), .dStall(dStall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for memEn, then answers with memDone one cycle later.
    task automatic serve(input logic [15:0] rd, output logic got, output logic [15:0] addr,
                         output logic wr, output logic [15:0] wdata);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (memEn) got = 1'b1;
            else tick();
        end
        addr = memAddr;
        wr = memWr;
        wdata = memWrData;
        if (got) begin
            tick();
            memDone = 1'b1;
            memRdData = rd;
            tick();
            memDone = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({memEn, memWr, iDone, dDone, err} !== 5'b0 || memAddr !== 16'h0 || memWrData !== 16'h0
            || iData !== 16'h0 || dData !== 16'h0) begin
            failures++;
            $display("FAIL reset: en=%b wr=%b id=%b dd=%b err=%b addr=%h wd=%h idata=%h ddata=%h, all required 0",
                     memEn, memWr, iDone, dDone, err, memAddr, memWrData, iData, dData);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (memEn !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: memEn=%b err=%b required 0 0", memEn, err);
        end
    endtask

    task automatic test_single_fetch();
        iReq = 1'b1;
        iAddr = 16'h0040;
        #1;
        checks++;
        if (iStall !== 1'b1) begin failures++; $display("FAIL fetch_stall_req: iStall=%b required 1", iStall); end
        tick();
        checks++;
        if (memEn !== 1'b1 || memAddr !== 16'h0040 || memWr !== 1'b0) begin
            failures++;
            $display("FAIL fetch_grant: memEn=%b addr=%h wr=%b required 1 0040 0", memEn, memAddr, memWr);
        end
        tick();
        checks++;
        if (memEn !== 1'b0) begin failures++; $display("FAIL fetch_en_pulse: memEn=%b required 0", memEn); end
        tick();
        memDone = 1'b1;
        memRdData = 16'h1234;
        tick();
        memDone = 1'b0;
        #1;
        checks++;
        if (iDone !== 1'b1 || iData !== 16'h1234 || iStall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done: iDone=%b iData=%h iStall=%b required 1 1234 0", iDone, iData, iStall);
        end
        iReq = 1'b0;
        tick();
        checks++;
        if (iDone !== 1'b0 || iStall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_after: iDone=%b iStall=%b required 0 0", iDone, iStall);
        end
    endtask

    task automatic test_starvation();
        logic got, wr;
        logic [15:0] addr, wd;
        iReq = 1'b1;
        iAddr = 16'h0300;
        dReq = 1'b1;
        dWr = 1'b0;
        dAddr = 16'h0100;
        #1;
        checks++;
        if (iStall !== 1'b1 || dStall !== 1'b1) begin
            failures++;
            $display("FAIL starve_stalls: iStall=%b dStall=%b required 1 1", iStall, dStall);
        end
        for (int n = 0; n < 6; n++) begin
            logic expD;
            expD = (n % 3) != 2;
            serve(expD ? 16'hBEEF : 16'h7777, got, addr, wr, wd);
            checks++;
            if (!got || addr !== (expD ? 16'h0100 : 16'h0300) || (expD ? dDone : iDone) !== 1'b1) begin
                failures++;
                $display("FAIL starve_order[%0d]: got=%b addr=%h iDone=%b dDone=%b required winner %s",
                         n, got, addr, iDone, dDone, expD ? "D@0100" : "I@0300");
            end
        end
        iReq = 1'b0;
        dReq = 1'b0;
        tick();
        checks++;
        if (dData !== 16'hBEEF || iData !== 16'h7777) begin
            failures++;
            $display("FAIL starve_data: dData=%h iData=%h required beef 7777", dData, iData);
        end
    endtask

    task automatic test_write();
        logic got, wr;
        logic [15:0] addr, wd;
        dReq = 1'b1;
        dWr = 1'b1;
        dAddr = 16'h0200;
        dWrData = 16'hA5A5;
        serve(16'h1111, got, addr, wr, wd);
        checks++;
        if (!got || addr !== 16'h0200 || wr !== 1'b1 || wd !== 16'hA5A5) begin
            failures++;
            $display("FAIL write_grant: got=%b addr=%h wr=%b wd=%h required 1 0200 1 a5a5", got, addr, wr, wd);
        end
        checks++;
        if (dDone !== 1'b1 || dData !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_done: dDone=%b dData=%h required 1 beef", dDone, dData);
        end
        dReq = 1'b0;
        dWr = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic got, wr;
        logic [15:0] addr, wd;
        bit seen;
        iReq = 1'b1;
        iAddr = 16'h0400;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (memEn) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || memAddr !== 16'h0400) begin
            failures++;
            $display("FAIL flush_grant: seen=%b addr=%h required 1 0400", seen, memAddr);
        end
        tick();
        iFlush = 1'b1;
        iReq = 1'b0;
        tick();
        iFlush = 1'b0;
        memDone = 1'b1;
        memRdData = 16'h5555;
        tick();
        memDone = 1'b0;
        checks++;
        if (iDone !== 1'b0 || iData !== 16'h7777 || err !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: iDone=%b iData=%h err=%b required 0 7777 0", iDone, iData, err);
        end
        iReq = 1'b1;
        iFlush = 1'b1;
        iAddr = 16'h0500;
        tick();
        checks++;
        if (memEn !== 1'b0 || iDone !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_block: memEn=%b iDone=%b required 0 0", memEn, iDone);
        end
        iFlush = 1'b0;
        serve(16'h6666, got, addr, wr, wd);
        checks++;
        if (!got || addr !== 16'h0500 || iDone !== 1'b1 || iData !== 16'h6666) begin
            failures++;
            $display("FAIL flush_refetch: got=%b addr=%h iDone=%b iData=%h required 1 0500 1 6666",
                     got, addr, iDone, iData);
        end
        iReq = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        bit anyEn;
        memDone = 1'b1;
        tick();
        memDone = 1'b0;
        checks++;
        if (err !== 1'b1 || iDone !== 1'b0 || dDone !== 1'b0) begin
            failures++;
            $display("FAIL err_idle_done: err=%b iDone=%b dDone=%b required 1 0 0", err, iDone, dDone);
        end
        iReq = 1'b1;
        iAddr = 16'h0600;
        anyEn = 1'b0;
        for (int k = 0; k < 5; k++) begin tick(); anyEn |= memEn; end
        checks++;
        if (anyEn || err !== 1'b1) begin
            failures++;
            $display("FAIL err_no_grant: memEn seen=%b err=%b required 0 1", anyEn, err);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        // Timeout: I request held, memory never answers.
        anyEn = 1'b0;
        for (int k = 0; k < 10 && !anyEn; k++) begin
            if (memEn) anyEn = 1'b1;
            else tick();
        end
        checks++;
        if (!anyEn || err !== 1'b0) begin
            failures++;
            $display("FAIL to_grant: memEn seen=%b err=%b required 1 0", anyEn, err);
        end
        repeat (31) tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL to_early: err=%b required 0", err); end
        tick();
        checks++;
        if (err !== 1'b1 || iDone !== 1'b0) begin
            failures++;
            $display("FAIL to_fire: err=%b iDone=%b required 1 0", err, iDone);
        end
        anyEn = 1'b0;
        for (int k = 0; k < 5; k++) begin tick(); anyEn |= memEn | iDone; end
        checks++;
        if (anyEn || err !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky: activity=%b err=%b required 0 1", anyEn, err);
        end
        iReq = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL rst_clear_err: err=%b required 0", err); end
        tick();
        rst = 1'b1;
        dReq = 1'b1;
        dAddr = 16'h0700;
        anyEn = 1'b0;
        for (int k = 0; k < 10 && !anyEn; k++) begin
            if (memEn) anyEn = 1'b1;
            else tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (!anyEn || memEn !== 1'b0 || memAddr !== 16'h0 || iData !== 16'h0 || dData !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_access: seen=%b memEn=%b addr=%h iData=%h dData=%h required 1 0 0 0 0",
                     anyEn, memEn, memAddr, iData, dData);
        end
        dReq = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (memEn !== 1'b0 || dDone !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_after: memEn=%b dDone=%b err=%b required 0 0 0", memEn, dDone, err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_starvation();
        test_write();
        test_flush();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
